// File: rtl/gravity_sensor_rx.sv
// Serial sensor frame receiver: oversampled 3-wire link, per-channel sample
// registers, and tilt / speed / random-bit decode for the game logic.
module gravity_sensor_rx #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned SAMPLE_W   = 12,
    parameter int unsigned FRAME_BITS = 24,
    parameter int unsigned TILT_CH    = 0,
    parameter int unsigned SPEED_CH   = 1,
    parameter int unsigned THRESH_NEG = 257,
    parameter int unsigned THRESH_POS = 320,
    parameter int unsigned HYST       = 32,
    parameter int unsigned RAND_W     = 3,
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                cs_n,
    input  logic                sclk,
    input  logic                sdi,
    output logic [1:0]          car_move,
    output logic                speed,
    output logic [RAND_W-1:0]   random_data,
    output logic                sample_valid,
    output logic [CH_W-1:0]     sample_ch,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                frame_err
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
    localparam int unsigned VW    = SAMPLE_W + 1;

    localparam logic signed [VW-1:0] LEFT_ON   = -$signed(VW'(THRESH_NEG));
    localparam logic signed [VW-1:0] LEFT_OFF  = -$signed(VW'(THRESH_NEG - HYST));
    localparam logic signed [VW-1:0] RIGHT_ON  = $signed(VW'(THRESH_POS));
    localparam logic signed [VW-1:0] RIGHT_OFF = $signed(VW'(THRESH_POS - HYST));

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t              state;
    logic [2:0]          cs_q;
    logic [2:0]          sclk_q;
    logic [2:0]          sdi_q;
    logic [CNT_W-1:0]    bit_cnt;
    // Only the trailing SAMPLE_W bits of a frame are ever kept.
    logic [SAMPLE_W-1:0] shreg;
    logic [CH_W-1:0]     ptr;
    logic [SAMPLE_W-1:0] ch_reg [CHANNELS];

    logic                cs_rise;
    logic                cs_fall;
    logic                sclk_rise;
    logic signed [VW-1:0] tilt_v;
    logic [1:0]          car_move_nxt;

    assign cs_rise   =  cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] &  cs_q[2];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];

    // Two-flop synchronisers plus an edge-detect stage; the cs_n edge stage
    // freezes during COMMIT so a back-to-back frame start is seen next cycle.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            cs_q   <= 3'b111;
            sclk_q <= 3'b111;
            sdi_q  <= 3'b000;
        end else begin
            cs_q[1:0] <= {cs_q[0], cs_n};
            if (state != COMMIT) begin
                cs_q[2] <= cs_q[1];
            end
            sclk_q <= {sclk_q[1:0], sclk};
            sdi_q  <= {sdi_q[1:0], sdi};
        end
    end

    // Frame FSM: shift on sclk rises, validate length on cs_n rise, commit.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            ptr          <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            frame_err    <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                ch_reg[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        if (bit_cnt == CNT_W'(FRAME_BITS)) begin
                            state <= COMMIT;
                        end else begin
                            frame_err <= 1'b1;
                            ptr       <= '0;
                            state     <= IDLE;
                        end
                    end else if (sclk_rise) begin
                        shreg <= {shreg[SAMPLE_W-2:0], sdi_q[2]};
                        if (bit_cnt != CNT_W'(FRAME_BITS + 1)) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    ch_reg[ptr]  <= shreg;
                    sample_valid <= 1'b1;
                    sample_ch    <= ptr;
                    sample_data  <= shreg;
                    if (ptr == CH_W'(CHANNELS - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tilt with hysteresis; an active tilt is held until it leaves its release band.
    always_comb begin
        tilt_v       = VW'($signed(ch_reg[TILT_CH]));
        car_move_nxt = 2'b00;
        if (car_move == 2'b10 && tilt_v <= LEFT_OFF) begin
            car_move_nxt = 2'b10;
        end else if (car_move == 2'b01 && tilt_v >= RIGHT_OFF) begin
            car_move_nxt = 2'b01;
        end else if (tilt_v <= LEFT_ON) begin
            car_move_nxt = 2'b10;
        end else if (tilt_v >= RIGHT_ON) begin
            car_move_nxt = 2'b01;
        end
    end

    // Game outputs follow the committed channel one cycle after sample_valid.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            car_move    <= 2'b00;
            speed       <= 1'b0;
            random_data <= '0;
        end else if (sample_valid) begin
            if (sample_ch == CH_W'(TILT_CH)) begin
                car_move <= car_move_nxt;
            end
            if (sample_ch == CH_W'(SPEED_CH)) begin
                speed       <= ch_reg[SPEED_CH][SAMPLE_W-1];
                random_data <= ch_reg[SPEED_CH][RAND_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_gravity_sensor_rx.sv
// Directed bench for gravity_sensor_rx: vector table of frames plus
// hand-written sequences for short frames, resets, stray clocks and back-to-back.
module tb_gravity_sensor_rx;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    logic cs_n  = 1'b1;
    logic sclk  = 1'b1;
    logic sdi   = 1'b0;

    logic [1:0]  car_move;
    logic        speed;
    logic [2:0]  random_data;
    logic        sample_valid;
    logic [0:0]  sample_ch;
    logic [11:0] sample_data;
    logic        frame_err;

    logic [1:0]  car_move3;
    logic        speed3;
    logic [2:0]  random_data3;
    logic        sample_valid3;
    logic [1:0]  sample_ch3;
    logic [11:0] sample_data3;
    logic        frame_err3;

    gravity_sensor_rx dut (
        .clk1(clk1), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .sdi(sdi),
        .car_move(car_move), .speed(speed), .random_data(random_data),
        .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .frame_err(frame_err)
    );

    gravity_sensor_rx #(.CHANNELS(3)) dut3 (
        .clk1(clk1), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .sdi(sdi),
        .car_move(car_move3), .speed(speed3), .random_data(random_data3),
        .sample_valid(sample_valid3), .sample_ch(sample_ch3),
        .sample_data(sample_data3), .frame_err(frame_err3)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;

    int          sv_cnt  = 0;
    int          fe_cnt  = 0;
    int          sv3_cnt = 0;
    logic [0:0]  last_ch   = '0;
    logic [11:0] last_data = '0;
    logic [1:0]  ch3_log [16];
    logic [11:0] d3_log  [16];

    // Event recorder, sampled mid-cycle.
    always @(negedge clk1) begin
        if (sample_valid === 1'b1) begin
            sv_cnt    = sv_cnt + 1;
            last_ch   = sample_ch;
            last_data = sample_data;
        end
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
        if (sample_valid3 === 1'b1) begin
            if (sv3_cnt < 16) begin
                ch3_log[sv3_cnt] = sample_ch3;
                d3_log[sv3_cnt]  = sample_data3;
            end
            sv3_cnt = sv3_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b1;
        sdi   = 1'b0;
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic shift_bits(input logic [31:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk = 1'b0;
            sdi  = word[i];
            repeat (4) @(negedge clk1);
            sclk = 1'b1;
            repeat (4) @(negedge clk1);
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits, input int gap,
                              input bit lat, input logic [1:0] lat_car);
        cs_n = 1'b0;
        repeat (4) @(negedge clk1);
        shift_bits(word, nbits);
        cs_n = 1'b1;
        if (lat) begin
            repeat (3) @(negedge clk1);
            chk("lat_early", 32'(sample_valid), 32'd0);
            @(negedge clk1);
            chk("lat_valid", 32'(sample_valid), 32'd1);
            chk("lat_car_hold", 32'(car_move), 32'd0);
            @(negedge clk1);
            chk("lat_car_upd", 32'(car_move), 32'(lat_car));
            chk("lat_one_cycle", 32'(sample_valid), 32'd0);
        end
        repeat (gap) @(negedge clk1);
    endtask

    typedef struct {
        logic [11:0] val;
        logic        ch;
        logic [1:0]  car;
        logic        spd;
        logic [2:0]  rnd;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int sv0;
        int fe0;
        int s3;
        logic [11:0] junk;
        logic [11:0] b2b_val [5];
        int          b2b_gap [5];
        logic [1:0]  b2b_ch  [5];

        vecs[0]  = '{12'hEFF, 1'b0, 2'b10, 1'b0, 3'd0};
        vecs[1]  = '{12'h805, 1'b1, 2'b10, 1'b1, 3'd5};
        vecs[2]  = '{12'h140, 1'b0, 2'b01, 1'b1, 3'd5};
        vecs[3]  = '{12'h000, 1'b1, 2'b01, 1'b0, 3'd0};
        vecs[4]  = '{12'h125, 1'b0, 2'b01, 1'b0, 3'd0};
        vecs[5]  = '{12'h000, 1'b1, 2'b01, 1'b0, 3'd0};
        vecs[6]  = '{12'h11F, 1'b0, 2'b00, 1'b0, 3'd0};
        vecs[7]  = '{12'h000, 1'b1, 2'b00, 1'b0, 3'd0};
        vecs[8]  = '{12'h000, 1'b0, 2'b00, 1'b0, 3'd0};
        vecs[9]  = '{12'h000, 1'b1, 2'b00, 1'b0, 3'd0};
        vecs[10] = '{12'hEFF, 1'b0, 2'b10, 1'b0, 3'd0};
        vecs[11] = '{12'h7FB, 1'b1, 2'b10, 1'b0, 3'd3};
        vecs[12] = '{12'hF1A, 1'b0, 2'b10, 1'b0, 3'd3};
        vecs[13] = '{12'h000, 1'b1, 2'b10, 1'b0, 3'd0};
        vecs[14] = '{12'hF20, 1'b0, 2'b00, 1'b0, 3'd0};
        vecs[15] = '{12'h800, 1'b1, 2'b00, 1'b1, 3'd0};
        vecs[16] = '{12'h13F, 1'b0, 2'b00, 1'b1, 3'd0};
        vecs[17] = '{12'h001, 1'b1, 2'b00, 1'b0, 3'd1};
        vecs[18] = '{12'h800, 1'b0, 2'b10, 1'b0, 3'd1};
        vecs[19] = '{12'h007, 1'b1, 2'b10, 1'b0, 3'd7};
        vecs[20] = '{12'h7FF, 1'b0, 2'b01, 1'b0, 3'd7};
        vecs[21] = '{12'hFFF, 1'b1, 2'b01, 1'b1, 3'd7};

        @(negedge clk1);
        do_reset();
        chk("rst_car", 32'(car_move), 32'd0);
        chk("rst_speed", 32'(speed), 32'd0);
        chk("rst_rand", 32'(random_data), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_ch", 32'(sample_ch), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst3_data", 32'(sample_data3), 32'd0);
        repeat (4) @(negedge clk1);

        // Vector table: one frame per entry, upper 12 frame bits are junk.
        for (int i = 0; i < NV; i++) begin
            sv0  = sv_cnt;
            junk = 12'(32'h5A3 + 32'(i) * 32'd37);
            send_frame({8'h00, junk, vecs[i].val}, 24, 8, i == 0, vecs[i].car);
            chk($sformatf("tbl%0d_count", i), 32'(sv_cnt - sv0), 32'd1);
            chk($sformatf("tbl%0d_ch", i), 32'(last_ch), 32'(vecs[i].ch));
            chk($sformatf("tbl%0d_data", i), 32'(last_data), 32'(vecs[i].val));
            chk($sformatf("tbl%0d_car", i), 32'(car_move), 32'(vecs[i].car));
            chk($sformatf("tbl%0d_speed", i), 32'(speed), 32'(vecs[i].spd));
            chk($sformatf("tbl%0d_rand", i), 32'(random_data), 32'(vecs[i].rnd));
        end

        // Short frame after ch0 realigns the pointer.
        send_frame({8'h00, 12'hABC, 12'h123}, 24, 8, 1'b0, 2'b00);
        chk("short_pre_ch", 32'(last_ch), 32'd0);
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_frame({8'h00, 12'hABC, 12'h321}, 20, 8, 1'b0, 2'b00);
        chk("short_err", 32'(fe_cnt - fe0), 32'd1);
        chk("short_novalid", 32'(sv_cnt - sv0), 32'd0);
        send_frame({8'h00, 12'h0F0, 12'h456}, 24, 8, 1'b0, 2'b00);
        chk("short_next_ch", 32'(last_ch), 32'd0);
        chk("short_next_data", 32'(last_data), 32'h456);
        chk("short_next_car", 32'(car_move), 32'd1);

        // Reset in the middle of a frame.
        fe0 = fe_cnt;
        sv0 = sv_cnt;
        cs_n = 1'b0;
        repeat (4) @(negedge clk1);
        shift_bits(32'h00ABCDEF, 10);
        do_reset();
        chk("mid_car", 32'(car_move), 32'd0);
        chk("mid_speed", 32'(speed), 32'd0);
        chk("mid_rand", 32'(random_data), 32'd0);
        chk("mid_ch", 32'(sample_ch), 32'd0);
        chk("mid_data", 32'(sample_data), 32'd0);
        repeat (10) @(negedge clk1);
        chk("mid_noerr", 32'(fe_cnt - fe0), 32'd0);
        chk("mid_novalid", 32'(sv_cnt - sv0), 32'd0);
        send_frame({8'h00, 12'h777, 12'hEFF}, 24, 8, 1'b0, 2'b00);
        chk("mid_next_ch", 32'(last_ch), 32'd0);
        chk("mid_next_data", 32'(last_data), 32'hEFF);
        chk("mid_next_car", 32'(car_move), 32'd2);

        // Stray sclk activity while deselected.
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        for (int k = 0; k < 8; k++) begin
            sclk = 1'b0;
            sdi  = ~sdi;
            repeat (2) @(negedge clk1);
            sclk = 1'b1;
            repeat (2) @(negedge clk1);
        end
        sdi = 1'b0;
        repeat (8) @(negedge clk1);
        chk("stray_novalid", 32'(sv_cnt - sv0), 32'd0);
        chk("stray_noerr", 32'(fe_cnt - fe0), 32'd0);
        chk("stray_data", 32'(sample_data), 32'hEFF);
        chk("stray_car", 32'(car_move), 32'd2);
        chk("stray_speed", 32'(speed), 32'd0);
        send_frame({8'h00, 12'h000, 12'h805}, 24, 8, 1'b0, 2'b00);
        chk("stray_next_ch", 32'(last_ch), 32'd1);
        chk("stray_next_speed", 32'(speed), 32'd1);
        chk("stray_next_rand", 32'(random_data), 32'd5);

        // Back-to-back frames with short deselect gaps, three-channel build.
        b2b_val = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
        b2b_gap = '{2, 2, 2, 1, 10};
        b2b_ch  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        do_reset();
        repeat (4) @(negedge clk1);
        s3  = sv3_cnt;
        sv0 = sv_cnt;
        for (int k = 0; k < 5; k++) begin
            send_frame({8'h00, 12'hC3C, b2b_val[k]}, 24, b2b_gap[k], 1'b0, 2'b00);
        end
        chk("b2b_count3", 32'(sv3_cnt - s3), 32'd5);
        chk("b2b_count2", 32'(sv_cnt - sv0), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (s3 + k < 16) begin
                chk($sformatf("b2b%0d_ch", k), 32'(ch3_log[s3 + k]), 32'(b2b_ch[k]));
                chk($sformatf("b2b%0d_data", k), 32'(d3_log[s3 + k]), 32'(b2b_val[k]));
            end
        end
        chk("b2b_noerr3", 32'(frame_err3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
